// File: rtl/fta_bridge64to128.sv
// fta_bridge64to128: upsizing bridge from a 64-bit FTA initiator onto the 128-bit FTA fabric.
//
// Requests are registered onto the 128-bit side, with write data replicated on both halves and
// byte selects steered into the half chosen by padr[3]. A small tracking table remembers the
// lane of every outstanding transaction, keyed by tid. Each returning response uses that table
// to pick the matching 64-bit half of the read data.
//
// Ports:
//   rst_i          synchronous active-high reset
//   clk_i          clock
//   s_req          request from the 64-bit initiator
//   s_resp         response to the 64-bit initiator (stall is combinational; all else registered)
//   m_req          registered request to the 128-bit fabric
//   m_resp         response from the 128-bit fabric
//   outstanding_o  number of valid tracking entries

package fta_bridge64to128_pkg;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  bte;
    logic [2:0]  cti;
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic [31:0] padr;
    logic [7:0]  sel;
    logic [63:0] dat;
  } fta_cmd_request64_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [1:0]   bte;
    logic [2:0]   cti;
    logic [3:0]   cid;
    logic [7:0]   tid;
    logic [31:0]  padr;
    logic [15:0]  sel;
    logic [127:0] data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic        stall;
    logic        next;
    logic        ack;
    logic        rty;
    logic        err;
    logic [3:0]  pri;
    logic [31:0] adr;
    logic [63:0] dat;
  } fta_cmd_response64_t;

  typedef struct packed {
    logic [3:0]   cid;
    logic [7:0]   tid;
    logic         stall;
    logic         next;
    logic         ack;
    logic         rty;
    logic         err;
    logic [3:0]   pri;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

endpackage

module fta_bridge64to128
  import fta_bridge64to128_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      rst_i,
  input  logic                      clk_i,
  input  fta_cmd_request64_t        s_req,
  output fta_cmd_response64_t       s_resp,
  output fta_cmd_request128_t       m_req,
  input  fta_cmd_response128_t      m_resp,
  output logic [$clog2(DEPTH):0]    outstanding_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  fta_cmd_request128_t m_req_q, m_req_d;
  fta_cmd_response64_t s_resp_q, s_resp_d;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      lane_q, lane_d;
  logic [DEPTH-1:0][7:0] tid_q, tid_d;

  logic            alloc_found;
  logic [IdxW-1:0] alloc_idx;
  logic            match_found;
  logic [IdxW-1:0] match_idx;
  logic            full;
  logic            acc;
  logic            resp_evt;
  logic            lane;
  logic            resp_lane;
  logic [CntW-1:0] cnt;

  assign lane     = s_req.padr[3];
  assign resp_evt = m_resp.ack | m_resp.err | m_resp.rty;

  // Lowest free slot, searched on the registered valids so a slot released this cycle is
  // not reallocated until the next one.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IdxW'(i);
      end
    end
  end

  // No free slot is exactly "every entry valid".
  assign full = ~alloc_found;
  assign acc  = s_req.cyc & s_req.stb & ~full & ~m_resp.stall;

  // Lowest-index valid entry with a matching tid retires first.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (resp_evt && valid_q[i] && (tid_q[i] == m_resp.tid) && !match_found) begin
        match_found = 1'b1;
        match_idx   = IdxW'(i);
      end
    end
  end

  // Unmatched responses fall back to the low half.
  assign resp_lane = match_found & lane_q[match_idx];

  always_comb begin
    valid_d = valid_q;
    lane_d  = lane_q;
    tid_d   = tid_q;
    if (match_found) begin
      valid_d[match_idx] = 1'b0;
    end
    // Alloc targets an invalid entry and match a valid one, so they never collide.
    if (acc) begin
      valid_d[alloc_idx] = 1'b1;
      lane_d[alloc_idx]  = lane;
      tid_d[alloc_idx]   = s_req.tid;
    end
  end

  always_comb begin
    m_req_d = m_req_q;
    if (acc) begin
      m_req_d.cyc   = 1'b1;
      m_req_d.stb   = 1'b1;
      m_req_d.we    = s_req.we;
      m_req_d.bte   = s_req.bte;
      m_req_d.cti   = s_req.cti;
      m_req_d.cid   = s_req.cid;
      m_req_d.tid   = s_req.tid;
      m_req_d.padr  = s_req.padr;
      m_req_d.sel   = lane ? {s_req.sel, 8'h00} : {8'h00, s_req.sel};
      m_req_d.data1 = {2{s_req.dat}};
    end else begin
      m_req_d.cyc   = 1'b0;
      m_req_d.stb   = 1'b0;
      m_req_d.we    = 1'b0;
      m_req_d.sel   = '0;
      m_req_d.padr  = 32'hFFFF_FFFF;
      m_req_d.data1 = '0;
    end
  end

  always_comb begin
    s_resp_d       = '0;
    s_resp_d.dat   = resp_lane ? m_resp.dat[127:64] : m_resp.dat[63:0];
    s_resp_d.ack   = m_resp.ack;
    s_resp_d.err   = m_resp.err;
    s_resp_d.rty   = m_resp.rty;
    s_resp_d.next  = m_resp.next;
    s_resp_d.cid   = m_resp.cid;
    s_resp_d.tid   = m_resp.tid;
    s_resp_d.adr   = m_resp.adr;
    s_resp_d.pri   = m_resp.pri;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_req_q  <= '0;
      s_resp_q <= '0;
      valid_q  <= '0;
      lane_q   <= '0;
      tid_q    <= '0;
    end else begin
      m_req_q  <= m_req_d;
      s_resp_q <= s_resp_d;
      valid_q  <= valid_d;
      lane_q   <= lane_d;
      tid_q    <= tid_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt = cnt + CntW'(valid_q[i]);
    end
  end

  assign outstanding_o = cnt;
  assign m_req         = m_req_q;

  always_comb begin
    s_resp       = s_resp_q;
    s_resp.stall = full | m_resp.stall;
  end

endmodule

// File: doc/fta_bridge64to128.md
# fta_bridge64to128

Upsizing bridge from a 64-bit FTA initiator (CPU-side or DMA master) onto the 128-bit FTA I/O fabric. Registers requests in both directions, steers 64-bit write data and byte selects into the correct half of the 128-bit lane, and records which half each outstanding transaction targets. When the response returns, the bridge selects the matching 64-bit half using the recorded entry, keyed by `tid`. It complements the 128-to-64 downsizing I/O bridge on the same fabric.

## Interface
- `DEPTH`, 4: number of outstanding-transaction tracking entries, legal range 2..16.
- `rst_i`  in  1  synchronous, active-high reset.
- `clk_i`  in  1  single clock for all logic.
- `s_req`  in  fta_cmd_request64_t  request from the 64-bit initiator.
- `s_resp`  out  fta_cmd_response64_t  response to the 64-bit initiator.
- `m_req`  out  fta_cmd_request128_t  request to the 128-bit fabric.
- `m_resp`  in  fta_cmd_response128_t  response from the 128-bit fabric.
- `outstanding_o`  out  $clog2(DEPTH)+1  count of valid tracking entries, for debug and verification.

## Operation
- Lane bit is `L = s_req.padr[3]`.
- Accept condition is `acc = s_req.cyc & s_req.stb & ~full & ~m_resp.stall`, where `full` means all DEPTH entries are valid.
- Request path: on `acc`, the following fields are registered into `m_req`.
  - `cyc=1`, `stb=1`.
  - `bte`, `cti`, `cid`, `tid`, `padr`, `we` copied unchanged.
  - `sel = L ? {s_req.sel, 8'h00} : {8'h00, s_req.sel}`.
  - `data1 = {2{s_req.dat}}`.
- When not `acc`, `m_req` is driven idle: `cyc=0`, `stb=0`, `we=0`, `sel=0`, `padr=32'hFFFFFFFF`, `data1=0`. Other fields hold.
- Tracking table: DEPTH entries, each holding {valid, tid, lane}.
  - On `acc`, the lowest-index entry that is invalid becomes valid, and records `s_req.tid` and `L`.
  - The free vector used for allocation is sampled before this cycle's release. A slot freed in the same cycle is therefore not reusable until the next cycle.
- Response path: a response event is `m_resp.ack | m_resp.err | m_resp.rty`.
  - Matching: the lowest-index valid entry whose `tid == m_resp.tid` is the match. Its lane selects the data half, and the entry is cleared in the same cycle.
  - No match: lane 0 is used, no entry is freed, and the response is still forwarded.
- `s_resp` registered fields:
  - `dat = lane ? m_resp.dat[127:64] : m_resp.dat[63:0]`.
  - `ack`, `err`, `rty`, `next`, `cid`, `tid`, `adr`, `pri` copied from `m_resp`.
- `s_resp.stall = full | m_resp.stall`. This field is combinational and is the only unregistered output.
- Simultaneous allocate and free in one cycle: both take effect, and `outstanding_o` is unchanged.
- Multiple entries may share a `tid`. They are retired lowest-index first.
- Reset mid-transaction: all entries are invalidated. Responses arriving after reset are treated as no-match.

## Timing
- Reset values:
  - `m_req` is all zero, including `padr=0`.
  - `s_resp` registered fields are all zero.
  - All table entries are invalid and `outstanding_o=0`.
  - `s_resp.stall` follows its combinational equation, so it is 0 out of reset when `m_resp.stall=0`.
- Request latency is 1 clock: `acc` at edge N produces `m_req.cyc=1` after edge N.
- Response latency is 1 clock: a response event at edge N appears on `s_resp` after edge N.
- Table update: allocation and release are both visible in the table after edge N. `outstanding_o` reflects the registered table.
- Stall: while `s_resp.stall=1`, the initiator must hold its request. Nothing is forwarded, and `m_req` stays idle.
- Back-to-back: one request can be accepted per clock until the table is full.
- Throughput at `DEPTH` outstanding is limited only by response return rate.

## Test plan
- Read of the low lane: send a read with `padr=32'hFFD0_0000`, `sel=8'hFF`, `tid=5`.
  - Next cycle, `m_req.sel=16'h00FF` and `outstanding_o=1`.
  - Return an ack with `tid=5` and `dat=128'hAAAA..._5555...`. Next cycle, `s_resp.dat=64'h5555_5555_5555_5555` and `outstanding_o=0`.
- High-lane write: send a write with `padr=32'hFFD0_0008`, `sel=8'h0F`, `dat=64'h1122334455667788`.
  - Next cycle, `m_req.sel=16'h0F00` and `data1=128'h11223344556677881122334455667788`.
- Fill and stall: issue 4 requests back-to-back with no responses. `outstanding_o=4` and `s_resp.stall=1`.
  - A 5th request is not forwarded, and `m_req.cyc` stays 0.
  - One ack clears the stall on the following cycle, and the held request is then forwarded.
- Out-of-order and simultaneous events:
  - Issue tid 1 to the high lane and tid 2 to the low lane.
  - Respond tid 2 first, then tid 1. Each response returns the correct half.
  - Also respond in the same cycle as a new request is accepted. `outstanding_o` is unchanged that cycle.
- Unmatched response and mid-operation reset:
  - An ack with an unknown tid forwards the low half and leaves `outstanding_o` unchanged.
  - Asserting `rst_i` with 3 outstanding entries zeroes `m_req`, `s_resp` and `outstanding_o` on the next edge.
